i2c_byte_tx: RTL

- I2C master write sequencer that sits alongside the SCL phase generator in the I2C path.
- On a start request it emits START, a 7-bit address with W=0, ACK check, one data byte, ACK check, then STOP.
- It drives SCL in lock-step with SDA and flags the result (done/nack) to the upstream control FSM.
- SCL is generated internally from a quarter-bit divider, so the SDA/SCL relationship is owned by one block.

---
 rtl/i2c_byte_tx.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_byte_tx.sv
// i2c_byte_tx: I2C master write sequencer. Emits START, 7-bit address + W,
// ACK check, one data byte, ACK check, STOP, then pulses done for one cycle.
// SCL is generated here from a quarter-bit divider (DIV clk4 cycles per quarter).
// Optional build macro I2C_CLK_STRETCH_EN: a slave holding SCL low while it is
// released (q2/q3) freezes the quarter counter.
module i2c_byte_tx #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk4,
    input  logic       reset4,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK1,
        S_DATA,
        S_ACK2,
        S_STOP,
        S_FIN
    } state_t;

    localparam logic [7:0] QMAX = 8'(DIV - 1);

    state_t     state, state_n;
    logic [1:0] phase, phase_n;
    logic [7:0] qcnt, qcnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] abyte, abyte_n;
    logic [7:0] dbyte, dbyte_n;
    logic       ackbit, ackbit_n;
    logic       scl_n, sda_oe_n, busy_n, done_n, nack_n;
    logic       hold, tick, slot_end, in_frame;

    assign in_frame = (state != S_IDLE) && (state != S_FIN);

`ifdef I2C_CLK_STRETCH_EN
    // Freeze the divider while SCL is released but a slave still holds it low
    always_comb hold = in_frame && phase[1] && scl && !scl_in;
`else
    logic unused_scl_in;

    // SCL readback has no function without clock stretching
    always_comb unused_scl_in = scl_in;

    // Divider never stalls
    always_comb hold = 1'b0;
`endif

    // Next-state: quarter/phase/bit counters, frame sequencing, ACK sampling
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        qcnt_n   = qcnt;
        bcnt_n   = bcnt;
        abyte_n  = abyte;
        dbyte_n  = dbyte;
        ackbit_n = ackbit;
        nack_n   = nack;
        tick     = 1'b0;
        slot_end = 1'b0;

        if (in_frame) begin
            tick = (qcnt == QMAX) && !hold;
            if (!hold) begin
                qcnt_n = (qcnt == QMAX) ? '0 : qcnt + 8'd1;
            end
            if (tick) begin
                phase_n = phase + 2'd1;
            end
            slot_end = tick && (phase == 2'd3);
            // ACK is sampled on the last cycle of q2 (SCL high, mid-pulse)
            if (tick && (phase == 2'd2) && ((state == S_ACK1) || (state == S_ACK2))) begin
                ackbit_n = sda_in;
                if (sda_in) begin
                    nack_n = 1'b1;
                end
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_START;
                    phase_n = '0;
                    qcnt_n  = '0;
                    bcnt_n  = '0;
                    abyte_n = {addr, 1'b0};
                    dbyte_n = data;
                    nack_n  = 1'b0;
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_n = S_ADDR;
                    bcnt_n  = '0;
                end
            end
            S_ADDR: begin
                if (slot_end) begin
                    bcnt_n = bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        state_n = S_ACK1;
                    end
                end
            end
            S_ACK1: begin
                if (slot_end) begin
                    state_n = ackbit ? S_STOP : S_DATA;
                end
            end
            S_DATA: begin
                if (slot_end) begin
                    bcnt_n = bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        state_n = S_ACK2;
                    end
                end
            end
            S_ACK2: begin
                if (slot_end) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    state_n = S_FIN;
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        scl_n    = 1'b1;
        sda_oe_n = 1'b0;
        busy_n   = 1'b1;
        done_n   = 1'b0;

        case (state_n)
            S_IDLE: begin
                busy_n = 1'b0;
            end
            S_START: begin
                sda_oe_n = phase_n[1];
            end
            S_ADDR: begin
                scl_n    = phase_n[1];
                sda_oe_n = ~abyte[~bcnt_n];
            end
            S_ACK1, S_ACK2: begin
                scl_n = phase_n[1];
            end
            S_DATA: begin
                scl_n    = phase_n[1];
                sda_oe_n = ~dbyte[~bcnt_n];
            end
            S_STOP: begin
                scl_n    = phase_n[1];
                sda_oe_n = (phase_n != 2'd3);
            end
            S_FIN: begin
                busy_n = 1'b0;
                done_n = 1'b1;
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases the bus at once
    always_ff @(posedge clk4) begin
        if (!reset4) begin
            state  <= S_IDLE;
            phase  <= '0;
            qcnt   <= '0;
            bcnt   <= '0;
            abyte  <= '0;
            dbyte  <= '0;
            ackbit <= 1'b0;
            scl    <= 1'b1;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            nack   <= 1'b0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            qcnt   <= qcnt_n;
            bcnt   <= bcnt_n;
            abyte  <= abyte_n;
            dbyte  <= dbyte_n;
            ackbit <= ackbit_n;
            scl    <= scl_n;
            sda_oe <= sda_oe_n;
            busy   <= busy_n;
            done   <= done_n;
            nack   <= nack_n;
        end
    end

endmodule
